// File: rtl/switch_debouncer_pkg.sv
// Shared constants and helpers for the switch debouncer slice.
// Holds the debounce-length defaults and the per-channel counter width function.
package switch_debouncer_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int unsigned DEBOUNCE_CYCLES_SIM     = 4;

  typedef enum logic [1:0] {
    CNT_CLEAR,
    CNT_INC,
    CNT_COMMIT
  } cnt_action_e;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: two-flop synchronizer, saturating stability counter,
// registered output level and (with SWITCH_DEBOUNCER_EDGE_EN) registered edge pulses.
module debounce_channel
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic        RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_in,
  output logic sw_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  cnt_action_e   action;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  end

  // >= keeps the counter saturating even if it were ever to overshoot
  always_comb begin
    action = CNT_CLEAR;
    if (sync2 != sw_out) begin
      action = (cnt >= CNT_LAST) ? CNT_COMMIT : CNT_INC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      sw_out <= RESET_VALUE;
    end else begin
      case (action)
        CNT_INC: cnt <= cnt + 1'b1;
        CNT_COMMIT: begin
          cnt    <= '0;
          sw_out <= sync2;
        end
        default: cnt <= '0;
      endcase
    end
  end

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  // Pulses are registered on the same edge that commits sw_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= (action == CNT_COMMIT) &&  sync2;
      fall_pulse <= (action == CNT_COMMIT) && !sync2;
    end
  end
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch/button debouncer built from independent debounce_channel slices.
// Define SWITCH_DEBOUNCER_EDGE_EN to compile in the rise/fall pulse outputs.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned         CHANNELS        = 3,
  parameter int unsigned         DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [CHANNELS-1:0] RESET_VALUE     = {CHANNELS{1'b0}}
) (
  input  logic                CLK_5_MHZ,
  input  logic                CPU_RESETN,
  input  logic [CHANNELS-1:0] sw_in,
  output logic [CHANNELS-1:0] sw_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (RESET_VALUE[i])
    ) u_ch (
      .clk        (CLK_5_MHZ),
      .rst_n      (CPU_RESETN),
      .sw_in      (sw_in[i]),
      .sw_out     (sw_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i])
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer (CHANNELS=3, DEBOUNCE_CYCLES=4, RESET_VALUE=0).
// Expected pulses are forced to zero when SWITCH_DEBOUNCER_EDGE_EN is not defined.
module tb_switch_debouncer;
  import switch_debouncer_pkg::*;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  localparam logic [2:0] EM = 3'b111;
`else
  localparam logic [2:0] EM = 3'b000;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sw_in = '0;
  logic [2:0] sw_out, rise_pulse, fall_pulse;

  typedef struct {
    logic [2:0] o;
    logic [2:0] r;
    logic [2:0] f;
    string      name;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  switch_debouncer #(
    .CHANNELS        (3),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_SIM),
    .RESET_VALUE     (3'b000)
  ) dut (
    .CLK_5_MHZ  (clk),
    .CPU_RESETN (rst_n),
    .sw_in      (sw_in),
    .sw_out     (sw_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always #100 clk = ~clk;

  // Monitor: one expectation per falling edge, popped in issue order
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (sw_out !== e.o || rise_pulse !== e.r || fall_pulse !== e.f) begin
        miscompares++;
        $display("FAIL %s @%0t: got sw_out=%b rise=%b fall=%b, expected sw_out=%b rise=%b fall=%b",
                 e.name, $time, sw_out, rise_pulse, fall_pulse, e.o, e.r, e.f);
      end
    end
  end

  // Drive one cycle's inputs just after the rising edge and queue what the next
  // falling edge must show.
  task automatic cyc(input logic [2:0] in, input logic [2:0] o, input logic [2:0] r,
                     input logic [2:0] f, input string name, input logic rst = 1'b1);
    exp_t e;
    @(posedge clk);
    #1;
    sw_in = in;
    rst_n = rst;
    e.o = o; e.r = r & EM; e.f = f & EM; e.name = name;
    q.push_back(e);
  endtask

  task automatic hold(input int unsigned n, input logic [2:0] in, input logic [2:0] o,
                      input string name);
    for (int unsigned i = 0; i < n; i++) cyc(in, o, 3'b000, 3'b000, name);
  endtask

  // Input change seen at the sixth following edge (2 sync + 4 debounce edges)
  task automatic change(input logic [2:0] in, input logic [2:0] old_o, input logic [2:0] new_o,
                        input string name, input logic rst = 1'b1);
    cyc(in, old_o, 3'b000, 3'b000, name, rst);
    for (int i = 0; i < 5; i++) cyc(in, old_o, 3'b000, 3'b000, name);
    cyc(in, new_o, new_o & ~old_o, old_o & ~new_o, {name, "_edge"});
  endtask

  initial begin
    // Reset held, then 20 quiet cycles
    for (int i = 0; i < 3; i++) cyc(3'b000, 3'b000, 3'b000, 3'b000, "in_reset", 1'b0);
    hold(20, 3'b000, 3'b000, "idle");

    // Single channel rise
    change(3'b001, 3'b000, 3'b001, "ch0_rise");
    hold(4, 3'b001, 3'b001, "ch0_hold");

    // Two 3-cycle glitches separated by one quiet cycle: counter must clear in between
    for (int i = 0; i < 3; i++) cyc(3'b011, 3'b001, 3'b000, 3'b000, "glitch_a");
    cyc(3'b001, 3'b001, 3'b000, 3'b000, "glitch_gap");
    for (int i = 0; i < 3; i++) cyc(3'b011, 3'b001, 3'b000, 3'b000, "glitch_b");
    hold(8, 3'b001, 3'b001, "glitch_after");

    // Exactly DEBOUNCE_CYCLES-long pulse passes, then falls back
    for (int i = 0; i < 4; i++) cyc(3'b011, 3'b001, 3'b000, 3'b000, "min_pulse");
    for (int i = 0; i < 2; i++) cyc(3'b001, 3'b001, 3'b000, 3'b000, "min_pulse_wait");
    cyc(3'b001, 3'b011, 3'b010, 3'b000, "min_pulse_rise");
    for (int i = 0; i < 3; i++) cyc(3'b001, 3'b011, 3'b000, 3'b000, "min_pulse_high");
    cyc(3'b001, 3'b001, 3'b000, 3'b010, "min_pulse_fall");
    hold(3, 3'b001, 3'b001, "min_pulse_after");

    // Return to zero, then all channels together
    change(3'b000, 3'b001, 3'b000, "ch0_fall");
    hold(3, 3'b000, 3'b000, "zero_hold");
    change(3'b111, 3'b000, 3'b111, "all_rise");
    hold(3, 3'b111, 3'b111, "all_high");
    change(3'b000, 3'b111, 3'b000, "all_fall");
    hold(3, 3'b000, 3'b000, "all_low");

    // Reset asserted while channel 2 has counted to 2; channel 0 is high
    change(3'b001, 3'b000, 3'b001, "pre_rst_rise");
    hold(2, 3'b001, 3'b001, "pre_rst_hold");
    for (int i = 0; i < 4; i++) cyc(3'b101, 3'b001, 3'b000, 3'b000, "ch2_counting");
    cyc(3'b101, 3'b000, 3'b000, 3'b000, "rst_forces_zero", 1'b0);
    for (int i = 0; i < 2; i++) cyc(3'b101, 3'b000, 3'b000, 3'b000, "rst_held", 1'b0);
    change(3'b101, 3'b000, 3'b101, "post_rst_rise", 1'b1);
    hold(5, 3'b101, 3'b101, "post_rst_hold");

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
